// File: rtl/hb_target.sv
`default_nettype none
// ============================================================================
//  Module   : hb_target
//  Purpose  : HyperBus target (responder) emulating a HyperRAM device for
//             closed-loop simulation and FPGA self-test of a HyperBus
//             controller. All HyperBus pins are oversampled in the wb_clk
//             domain (wb_clk >= 8x hb_clk). The 48-bit command/address is
//             decoded, the initial latency applied, then reads and writes
//             are served from an internal 2**MEM_AW x 16-bit word memory.
//             Register space: read address 0 returns ID0_VAL, any other
//             address returns CR0; register writes load CR0.
//  Ports    : wb_clk, wb_rst (async, active-low)  - system clock / reset
//             hb_clk_i, hb_cs_i, hb_rst_i         - HyperBus clock/CS#/RESET#
//             hb_dq_i / hb_dq_o / hb_dq_oe        - data bus
//             hb_rwds_i / hb_rwds_o / hb_rwds_oe  - RWDS (mask / strobe)
//             busy_o                              - state is not IDLE
//  Options  : HB_TARGET_DOUBLE_LATENCY_EN - RWDS high during CA and
//             4*LATENCY latency edges (2*LATENCY when undefined).
//  Revision : 1.0 - initial release
// ============================================================================
module hb_target #(
    parameter int          MEM_AW  = 10,
    parameter int          LATENCY = 6,
    parameter logic [15:0] ID0_VAL = 16'h0C81,
    parameter logic [15:0] CR0_RST = 16'h8F1F
) (
    input  logic       wb_clk,
    input  logic       wb_rst,
    input  logic       hb_clk_i,
    input  logic       hb_cs_i,
    input  logic       hb_rst_i,
    input  logic [7:0] hb_dq_i,
    output logic [7:0] hb_dq_o,
    output logic       hb_dq_oe,
    input  logic       hb_rwds_i,
    output logic       hb_rwds_o,
    output logic       hb_rwds_oe,
    output logic       busy_o
);

`ifdef HB_TARGET_DOUBLE_LATENCY_EN
    localparam logic c_ca_rwds  = 1'b1;
    localparam int   c_lat_mult = 4;
`else
    localparam logic c_ca_rwds  = 1'b0;
    localparam int   c_lat_mult = 2;
`endif

    localparam int         c_lat_edges = c_lat_mult * LATENCY;
    localparam logic [7:0] c_lat_init  = c_lat_edges[7:0];
    localparam int         c_depth     = 1 << MEM_AW;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CA    = 3'd1,
        ST_LAT   = 3'd2,
        ST_WDATA = 3'd3,
        ST_RDATA = 3'd4,
        ST_RWR   = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------
    // Input synchronizers: every HyperBus input sees the same 2-flop delay
    // so clock edges and data stay aligned after synchronization.
    // ------------------------------------------------------------------
    logic [1:0] r_clk_sync;
    logic [1:0] r_cs_sync;
    logic [1:0] r_rst_sync;
    logic [1:0] r_rwds_sync;
    logic [7:0] r_dq_s1;
    logic [7:0] r_dq_s2;

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            r_clk_sync  <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_rst_sync  <= 2'b00;
            r_rwds_sync <= 2'b00;
            r_dq_s1     <= 8'h00;
            r_dq_s2     <= 8'h00;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], hb_clk_i};
            r_cs_sync   <= {r_cs_sync[0], hb_cs_i};
            r_rst_sync  <= {r_rst_sync[0], hb_rst_i};
            r_rwds_sync <= {r_rwds_sync[0], hb_rwds_i};
            r_dq_s1     <= hb_dq_i;
            r_dq_s2     <= r_dq_s1;
        end
    end

    logic       w_clk_s;
    logic       w_cs_s;
    logic       w_rst_s;
    logic       w_rwds_s;
    logic [7:0] w_dq_s;

    assign w_clk_s  = r_clk_sync[1];
    assign w_cs_s   = r_cs_sync[1];
    assign w_rst_s  = r_rst_sync[1];
    assign w_rwds_s = r_rwds_sync[1];
    assign w_dq_s   = r_dq_s2;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic              r_clk_d;
    logic              r_cs_d;
    logic [39:0]       r_ca;
    logic [2:0]        r_cnt;
    logic [7:0]        r_lat;
    logic              r_rd;
    logic              r_reg;
    logic              r_lin;
    logic [MEM_AW-1:0] r_addr;
    logic              r_odd;
    logic [7:0]        r_whi;
    logic              r_mhi;
    logic [15:0]       r_cr0;
    logic [7:0]        r_dq_o;
    logic              r_rwds_o;
    logic              r_tog;
    logic [15:0]       r_mem [0:c_depth-1];

    // A CS# deassert in the same cycle as a clock edge discards that edge.
    logic w_edge;
    logic w_cs_fall;
    assign w_edge    = (w_clk_s ^ r_clk_d) & ~w_cs_s & w_rst_s;
    assign w_cs_fall = r_cs_d & ~w_cs_s;

    // Complete CA word as it stands once the byte on this edge is included.
    logic [47:0] w_ca_full;
    logic [31:0] w_ca_word;
    logic [MEM_AW-1:0] w_ca_addr;
    assign w_ca_full = {r_ca, w_dq_s};
    assign w_ca_word = {w_ca_full[44:16], w_ca_full[2:0]};
    assign w_ca_addr = w_ca_word[MEM_AW-1:0];

    // Address advance: linear wraps at the memory size, wrapped bursts
    // stay inside an aligned 16-word group.
    logic [MEM_AW-1:0] w_addr_inc;
    logic [MEM_AW-1:0] w_addr_wrap;
    logic [MEM_AW-1:0] w_addr_adv;
    assign w_addr_inc = r_addr + MEM_AW'(1);

    generate
        if (MEM_AW > 4) begin : g_wrap_grp
            assign w_addr_wrap = {r_addr[MEM_AW-1:4], w_addr_inc[3:0]};
        end else begin : g_wrap_all
            assign w_addr_wrap = w_addr_inc;
        end
    endgenerate

    assign w_addr_adv = r_lin ? w_addr_inc : w_addr_wrap;

    logic [15:0] w_rd_word;
    assign w_rd_word = r_reg ? ((r_addr == '0) ? ID0_VAL : r_cr0)
                             : r_mem[r_addr];

    logic w_mem_we;
    assign w_mem_we = (r_state == ST_WDATA) & w_edge & r_odd;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (!w_rst_s) begin
            w_state_nxt = ST_IDLE;
        end else if ((r_state != ST_IDLE) && w_cs_s) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        w_state_nxt = ST_CA;
                    end
                end
                ST_CA: begin
                    if (w_edge && (r_cnt == 3'd5)) begin
                        if (w_ca_full[46] && !w_ca_full[47]) begin
                            w_state_nxt = ST_RWR;
                        end else if (c_lat_edges == 0) begin
                            w_state_nxt = w_ca_full[47] ? ST_RDATA : ST_WDATA;
                        end else begin
                            w_state_nxt = ST_LAT;
                        end
                    end
                end
                ST_LAT: begin
                    if (w_edge && (r_lat == 8'd1)) begin
                        w_state_nxt = r_rd ? ST_RDATA : ST_WDATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            r_clk_d  <= 1'b0;
            r_cs_d   <= 1'b1;
            r_ca     <= 40'd0;
            r_cnt    <= 3'd0;
            r_lat    <= 8'd0;
            r_rd     <= 1'b0;
            r_reg    <= 1'b0;
            r_lin    <= 1'b0;
            r_addr   <= '0;
            r_odd    <= 1'b0;
            r_whi    <= 8'h00;
            r_mhi    <= 1'b0;
            r_cr0    <= CR0_RST;
            r_dq_o   <= 8'h00;
            r_rwds_o <= 1'b0;
            r_tog    <= 1'b0;
        end else begin
            r_clk_d <= w_clk_s;
            r_cs_d  <= w_cs_s;

            if (!w_rst_s) begin
                r_cr0 <= CR0_RST;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_cnt <= 3'd0;
                    end
                end
                ST_CA: begin
                    if (w_edge) begin
                        r_ca  <= w_ca_full[39:0];
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd5) begin
                            r_rd     <= w_ca_full[47];
                            r_reg    <= w_ca_full[46];
                            r_lin    <= w_ca_full[45];
                            r_addr   <= w_ca_addr;
                            r_lat    <= c_lat_init;
                            r_cnt    <= 3'd0;
                            r_odd    <= 1'b0;
                            r_rwds_o <= 1'b0;
                        end
                    end
                end
                ST_LAT: begin
                    if (w_edge) begin
                        r_lat <= r_lat - 8'd1;
                    end
                end
                ST_WDATA: begin
                    if (w_edge) begin
                        r_odd <= ~r_odd;
                        if (!r_odd) begin
                            r_whi <= w_dq_s;
                            r_mhi <= w_rwds_s;
                        end else begin
                            r_addr <= w_addr_adv;
                        end
                    end
                end
                ST_RDATA: begin
                    if (w_edge) begin
                        r_odd  <= ~r_odd;
                        r_dq_o <= r_odd ? w_rd_word[7:0] : w_rd_word[15:8];
                        if (r_odd && !r_reg) begin
                            r_addr <= w_addr_adv;
                        end
                    end
                end
                ST_RWR: begin
                    // CR0 is committed only once both bytes have arrived.
                    if (w_edge && (r_cnt != 3'd2)) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd0) begin
                            r_whi <= w_dq_s;
                        end else begin
                            r_cr0 <= {r_whi, w_dq_s};
                        end
                    end
                end
                default: begin
                end
            endcase

            // RWDS strobe follows the data byte by one wb_clk so the
            // controller always sees stable DQ at the RWDS transition.
            r_tog <= (r_state == ST_RDATA) & w_edge;
            if (r_tog) begin
                r_rwds_o <= ~r_rwds_o;
            end

            if (w_state_nxt == ST_IDLE) begin
                r_rwds_o <= 1'b0;
                r_tog    <= 1'b0;
                r_dq_o   <= 8'h00;
            end
        end
    end

    // Memory is intentionally not reset; bytes flagged by RWDS are kept.
    always_ff @(posedge wb_clk) begin
        if (w_mem_we) begin
            if (!r_mhi) begin
                r_mem[r_addr][15:8] <= r_whi;
            end
            if (!w_rwds_s) begin
                r_mem[r_addr][7:0] <= w_dq_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign hb_dq_o    = r_dq_o;
    assign hb_dq_oe   = (r_state == ST_RDATA);
    assign hb_rwds_oe = (r_state == ST_CA) || (r_state == ST_RDATA);
    assign hb_rwds_o  = (r_state == ST_CA) ? c_ca_rwds : r_rwds_o;
    assign busy_o     = (r_state != ST_IDLE);

    // CA bits outside the decoded fields are don't-care.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, w_ca_full[15:3], w_ca_word};

endmodule
`default_nettype wire

// File: tb/tb_hb_target.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hb_target
//  Purpose  : Self-checking bench for hb_target. A controller model drives
//             HyperBus transactions; expected read bytes (with the RWDS
//             level that should accompany them) go into a queue and a
//             monitor pops and compares on every RWDS transition.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hb_target;

    localparam int c_lat = 6;

    logic       wb_clk;
    logic       wb_rst;
    logic       hb_clk_i;
    logic       hb_cs_i;
    logic       hb_rst_i;
    logic [7:0] hb_dq_i;
    logic [7:0] hb_dq_o;
    logic       hb_dq_oe;
    logic       hb_rwds_i;
    logic       hb_rwds_o;
    logic       hb_rwds_oe;
    logic       busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] sb[$];
    logic       prev_rwds = 1'b0;

    hb_target #(
        .MEM_AW (10),
        .LATENCY(c_lat),
        .ID0_VAL(16'h0C81),
        .CR0_RST(16'h8F1F)
    ) u_dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .hb_clk_i  (hb_clk_i),
        .hb_cs_i   (hb_cs_i),
        .hb_rst_i  (hb_rst_i),
        .hb_dq_i   (hb_dq_i),
        .hb_dq_o   (hb_dq_o),
        .hb_dq_oe  (hb_dq_oe),
        .hb_rwds_i (hb_rwds_i),
        .hb_rwds_o (hb_rwds_o),
        .hb_rwds_oe(hb_rwds_oe),
        .busy_o    (busy_o)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every RWDS transition while the target drives the bus
    // delivers one byte.
    always @(negedge wb_clk) begin
        if (hb_dq_oe && hb_rwds_oe && (hb_rwds_o !== prev_rwds)) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL rd_unexpected: got %h with empty queue", {hb_rwds_o, hb_dq_o});
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                if ({hb_rwds_o, hb_dq_o} !== e) begin
                    n_bad++;
                    $display("FAIL rd_byte: got rwds/dq %h expected %h", {hb_rwds_o, hb_dq_o}, e);
                end
            end
        end
        prev_rwds = hb_rwds_o;
    end

    task automatic hb_edge(input logic [7:0] d, input logic m);
        hb_dq_i   = d;
        hb_rwds_i = m;
        #20;
        hb_clk_i  = ~hb_clk_i;
        #30;
    endtask

    task automatic send_ca(input logic rd, input logic rs, input logic lin,
                           input logic [31:0] wa, input int nbytes);
        logic [47:0] ca;
        ca = {rd, rs, lin, wa[31:3], 13'd0, wa[2:0]};
        hb_cs_i = 1'b0;
        #40;
        chk("ca_busy", busy_o, 1);
        chk("ca_rwds_oe", hb_rwds_oe, 1);
        chk("ca_rwds_o", hb_rwds_o, 0);
        for (int i = 0; i < nbytes; i++) begin
            hb_edge(ca[47-8*i -: 8], 1'b0);
        end
    endtask

    task automatic lat_edges();
        for (int i = 0; i < 2*c_lat; i++) begin
            hb_edge(8'h00, 1'b0);
        end
    endtask

    task automatic end_xfer();
        #20;
        hb_cs_i = 1'b1;
        #60;
        if (hb_clk_i) begin
            hb_clk_i = 1'b0;
            #20;
        end
    endtask

    task automatic mem_write(input logic [31:0] wa, input logic lin,
                             input logic [127:0] data, input int nb,
                             input logic [15:0] mask);
        send_ca(1'b0, 1'b0, lin, wa, 6);
        lat_edges();
        for (int i = 0; i < nb; i++) begin
            hb_edge(data[8*(nb-1-i) +: 8], mask[i]);
        end
        end_xfer();
    endtask

    task automatic do_read(input string nm, input logic [31:0] wa, input logic rs,
                           input logic lin, input logic [127:0] data, input int nb);
        send_ca(1'b1, rs, lin, wa, 6);
        lat_edges();
        for (int i = 0; i < nb; i++) begin
            logic lvl;
            lvl = ((i % 2) == 0);
            sb.push_back({lvl, data[8*(nb-1-i) +: 8]});
        end
        for (int i = 0; i < nb; i++) begin
            hb_edge(8'h00, 1'b0);
        end
        end_xfer();
        chk(nm, sb.size(), 0);
        sb.delete();
    endtask

    task automatic reg_write(input logic [15:0] v);
        send_ca(1'b0, 1'b1, 1'b0, 32'd0, 6);
        hb_edge(v[15:8], 1'b1);
        hb_edge(v[7:0], 1'b1);
        end_xfer();
    endtask

    task automatic abort_check(input string nm);
        hb_cs_i = 1'b1;
        repeat (4) @(negedge wb_clk);
        chk({nm, "_busy"}, busy_o, 0);
        chk({nm, "_dq_oe"}, hb_dq_oe, 0);
        chk({nm, "_rwds_oe"}, hb_rwds_oe, 0);
        if (hb_clk_i) begin
            hb_clk_i = 1'b0;
        end
        #40;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        wb_rst    = 1'b0;
        hb_clk_i  = 1'b0;
        hb_cs_i   = 1'b1;
        hb_rst_i  = 1'b1;
        hb_dq_i   = 8'h00;
        hb_rwds_i = 1'b0;
        #40;
        chk("rst_busy", busy_o, 0);
        chk("rst_dq_o", hb_dq_o, 0);
        chk("rst_dq_oe", hb_dq_oe, 0);
        chk("rst_rwds_o", hb_rwds_o, 0);
        chk("rst_rwds_oe", hb_rwds_oe, 0);
        wb_rst = 1'b1;
        #100;

        // 32-bit write of 5555_5555 and read back
        mem_write(32'd0, 1'b1, 128'h5555_5555, 4, 16'h0000);
        do_read("rd_5555", 32'd0, 1'b0, 1'b1, 128'h5555_5555, 4);

        // 16-byte linear burst
        mem_write(32'd0, 1'b1, 128'h01020304_05060708_090a0b0c_0d0e0f00, 16, 16'h0000);
        do_read("rd_burst", 32'd0, 1'b0, 1'b1, 128'h01020304_05060708_090a0b0c_0d0e0f00, 16);

        // Byte mask on the low byte
        mem_write(32'd2, 1'b1, 128'h1234, 2, 16'h0000);
        mem_write(32'd2, 1'b1, 128'hABCD, 2, 16'h0002);
        do_read("rd_mask", 32'd2, 1'b0, 1'b1, 128'hAB34, 2);

        // Register space
        reg_write(16'h8F17);
        do_read("rd_cr0", 32'd1, 1'b1, 1'b1, 128'h8F17_8F17, 4);
        do_read("rd_id0", 32'd0, 1'b1, 1'b1, 128'h0C81, 2);

        // Device reset restores CR0
        hb_rst_i = 1'b0;
        #100;
        hb_rst_i = 1'b1;
        #100;
        do_read("rd_cr0_rst", 32'd1, 1'b1, 1'b1, 128'h8F1F, 2);

        // Wrapped read across the 16-word group boundary
        mem_write(32'd14, 1'b1, 128'hE0E1_F0F1, 4, 16'h0000);
        mem_write(32'd16, 1'b1, 128'h1011_1213, 4, 16'h0000);
        do_read("rd_wrap", 32'd14, 1'b0, 1'b0, 128'hE0E1_F0F1_0102_0304, 8);

        // Linear wrap at the top of memory
        mem_write(32'd1023, 1'b1, 128'h7788_99AA, 4, 16'h0000);
        do_read("rd_top", 32'd1023, 1'b0, 1'b1, 128'h7788_99AA_0304, 6);

        // CS# deassert after 3 CA bytes
        send_ca(1'b0, 1'b0, 1'b1, 32'd2, 3);
        abort_check("abort_ca");

        // CS# deassert after one write data byte
        send_ca(1'b0, 1'b0, 1'b1, 32'd2, 6);
        lat_edges();
        hb_edge(8'h00, 1'b0);
        abort_check("abort_wr");
        do_read("rd_after_abort", 32'd2, 1'b0, 1'b1, 128'hAB34, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
